cpu_run_ctrl: RTL and testbench

//  Run/step/breakpoint sequencer for the single-cycle RISC-V CPU.

---
 rtl/cpu_run_ctrl_pkg.sv | 22 ++
 rtl/cpu_stop_detect.sv | 31 +++
 rtl/cpu_run_ctrl.sv | 133 +++++++++++++
 tb/tb_cpu_run_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_run_ctrl_pkg.sv
// Shared definitions for the CPU run/step/breakpoint sequencer.
//   run_state_e  : HALT/RUN/STEP encodings driven on run_state
//   halt_cause_e : reason for the most recent halt, driven on halt_cause
//   ECALL_INST   : instruction word that always stops execution
package cpu_run_ctrl_pkg;

  typedef enum logic [1:0] {
    StHalt = 2'b00,
    StRun  = 2'b01,
    StStep = 2'b10
  } run_state_e;

  typedef enum logic [1:0] {
    CauseReset = 2'b00,
    CauseCmd   = 2'b01,
    CauseBp    = 2'b10,
    CauseEcall = 2'b11
  } halt_cause_e;

  localparam logic [31:0] ECALL_INST = 32'h0000_0073;

endpackage

// File: rtl/cpu_stop_detect.sv
// Combinational stop detection for the run controller.
//   skip       in  : suppress detection for the instruction that caused the last stop
//   bp_en      in  : breakpoint enable
//   bp_addr    in  : breakpoint PC
//   pc         in  : current PC
//   inst       in  : current instruction
//   stop_hit   out : current instruction must not commit; controller halts
//   stop_cause out : cause to record (ECALL wins over a breakpoint)
module cpu_stop_detect
  import cpu_run_ctrl_pkg::*;
(
  input  logic        skip,
  input  logic        bp_en,
  input  logic [31:0] bp_addr,
  input  logic [31:0] pc,
  input  logic [31:0] inst,
  output logic        stop_hit,
  output halt_cause_e stop_cause
);

  logic is_ecall;
  logic is_bp;

  always_comb begin
    is_ecall   = (inst == ECALL_INST);
    is_bp      = bp_en && (pc == bp_addr);
    stop_hit   = !skip && (is_ecall || is_bp);
    stop_cause = is_ecall ? CauseEcall : CauseBp;
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step/breakpoint sequencer for the single-cycle CPU.
// Drives cpu_en, the commit enable gating every architectural update.
//   clk, rst   : clock, asynchronous active-low reset
//   cmd_run    : pulse, free-run
//   cmd_step   : pulse, execute step_num instructions (0 means 1) then halt
//   cmd_halt   : pulse, halt (highest priority command)
//   step_num   : instructions per step, sampled with cmd_step
//   bp_en      : breakpoint enable
//   bp_addr    : breakpoint PC
//   pc, inst   : current PC and instruction from IFetch
//   cnt_clr    : synchronous clear of the retired counter
//   cpu_en     : commit enable (combinational)
//   run_state  : 00 HALT, 01 RUN, 10 STEP
//   halt_cause : 00 reset, 01 command/step-done, 10 breakpoint, 11 ECALL
//   retired    : committed instruction count, wraps
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned STEP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_run,
  input  logic              cmd_step,
  input  logic              cmd_halt,
  input  logic [STEP_W-1:0] step_num,
  input  logic              bp_en,
  input  logic [31:0]       bp_addr,
  input  logic [31:0]       pc,
  input  logic [31:0]       inst,
  input  logic              cnt_clr,
  output logic              cpu_en,
  output logic [1:0]        run_state,
  output logic [1:0]        halt_cause,
  output logic [CNT_W-1:0]  retired
);

  run_state_e        state_q, state_d;
  halt_cause_e       cause_q, cause_d;
  logic [STEP_W-1:0] step_left_q, step_left_d;
  logic              skip_q, skip_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  logic        stop_hit;
  halt_cause_e stop_cause;

  cpu_stop_detect u_stop_detect (
    .skip       (skip_q),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .pc         (pc),
    .inst       (inst),
    .stop_hit   (stop_hit),
    .stop_cause (stop_cause)
  );

  // The stopping instruction never commits: stop_hit gates cpu_en in the same cycle.
  assign cpu_en     = (state_q != StHalt) && !stop_hit;
  assign run_state  = state_q;
  assign halt_cause = cause_q;
  assign retired    = retired_q;

  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    step_left_d = step_left_q;
    skip_d      = skip_q;

    // skip only needs to cover the first committed instruction after a resume.
    if (cpu_en) skip_d = 1'b0;

    case (state_q)
      StHalt: begin
        if (!cmd_halt) begin
          if (cmd_run) begin
            state_d = StRun;
          end else if (cmd_step) begin
            step_left_d = (step_num == '0) ? STEP_W'(1) : step_num;
            state_d     = StStep;
          end
        end
      end
      StRun: begin
        if (stop_hit) begin
          state_d = StHalt;
          cause_d = stop_cause;
          skip_d  = 1'b1;
        end else if (cmd_halt) begin
          state_d = StHalt;
          cause_d = CauseCmd;
        end
      end
      StStep: begin
        if (stop_hit) begin
          state_d     = StHalt;
          cause_d     = stop_cause;
          skip_d      = 1'b1;
          step_left_d = '0;
        end else begin
          // cpu_en is high here, so this instruction commits.
          step_left_d = step_left_q - STEP_W'(1);
          if (cmd_halt || (step_left_q == STEP_W'(1))) begin
            state_d = StHalt;
            cause_d = CauseCmd;
          end
        end
      end
      default: state_d = StHalt;
    endcase
  end

  always_comb begin
    retired_d = cnt_clr ? '0 : retired_q + CNT_W'(cpu_en);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StHalt;
      cause_q     <= CauseReset;
      step_left_q <= '0;
      skip_q      <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      step_left_q <= step_left_d;
      skip_q      <= skip_d;
      retired_q   <= retired_d;
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
module tb_cpu_run_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] ECL = 32'h0000_0073;

  logic        clk;
  logic        rst;
  logic        cmd_run, cmd_step, cmd_halt;
  logic [7:0]  step_num;
  logic        bp_en;
  logic [31:0] bp_addr, pc, inst;
  logic        cnt_clr;
  logic        cpu_en;
  logic [1:0]  run_state, halt_cause;
  logic [31:0] retired;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        run, step, halt;
    logic [7:0]  snum;
    logic        bpen;
    logic [31:0] bpaddr, pc, inst;
    logic        clr;
    logic        en;
    logic [1:0]  st, cause;
    logic [31:0] ret;
  } vec_t;

  vec_t vecs[$];

  cpu_run_ctrl #(.CNT_W(32), .STEP_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_run    (cmd_run),
    .cmd_step   (cmd_step),
    .cmd_halt   (cmd_halt),
    .step_num   (step_num),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .pc         (pc),
    .inst       (inst),
    .cnt_clr    (cnt_clr),
    .cpu_en     (cpu_en),
    .run_state  (run_state),
    .halt_cause (halt_cause),
    .retired    (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s @%0d: got %0h, want %0h", name, idx, got, want);
    end
  endtask

  task automatic add(input logic r, input logic s, input logic h, input logic [7:0] sn,
                     input logic be, input logic [31:0] ba, input logic [31:0] p,
                     input logic [31:0] i, input logic c, input logic en,
                     input logic [1:0] st, input logic [1:0] ca, input logic [31:0] rt);
    vec_t v;
    v.run = r; v.step = s; v.halt = h; v.snum = sn; v.bpen = be; v.bpaddr = ba;
    v.pc = p; v.inst = i; v.clr = c; v.en = en; v.st = st; v.cause = ca; v.ret = rt;
    vecs.push_back(v);
  endtask

  task automatic drive_idle();
    cmd_run = 0; cmd_step = 0; cmd_halt = 0; step_num = 0; cnt_clr = 0;
    bp_en = 0; bp_addr = 0; pc = 0; inst = NOP;
  endtask

  task automatic check_all(input string tag, input int idx, input logic en,
                           input logic [1:0] st, input logic [1:0] ca, input logic [31:0] rt);
    check({tag, ".cpu_en"}, idx, 32'(cpu_en), 32'(en));
    check({tag, ".run_state"}, idx, 32'(run_state), 32'(st));
    check({tag, ".halt_cause"}, idx, 32'(halt_cause), 32'(ca));
    check({tag, ".retired"}, idx, retired, rt);
  endtask

  initial begin
    // Columns: run step halt snum bpen bpaddr pc inst clr | en st cause ret
    // Free run from reset, halt by command, clear while halted.
    add(1, 0, 0, 0, 0, 0, 32'h00, NOP, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 10; k++) add(0, 0, 0, 0, 0, 0, 4 * (k - 1), NOP, 0, 1, 1, 0, k - 1);
    add(0, 0, 1, 0, 0, 0, 32'h28, NOP, 0, 1, 1, 0, 10);
    add(0, 0, 0, 0, 0, 0, 32'h2c, NOP, 0, 0, 0, 1, 11);
    add(0, 0, 0, 0, 0, 0, 32'h2c, NOP, 1, 0, 0, 1, 11);
    add(0, 0, 0, 0, 0, 0, 32'h00, NOP, 0, 0, 0, 1, 0);
    // Breakpoint at 0x10, then resume past it.
    add(1, 0, 0, 0, 1, 32'h10, 32'h00, NOP, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 1, 32'h10, 32'h00, NOP, 0, 1, 1, 1, 0);
    add(0, 0, 0, 0, 1, 32'h10, 32'h04, NOP, 0, 1, 1, 1, 1);
    add(0, 0, 0, 0, 1, 32'h10, 32'h08, NOP, 0, 1, 1, 1, 2);
    add(0, 0, 0, 0, 1, 32'h10, 32'h0c, NOP, 0, 1, 1, 1, 3);
    add(0, 0, 0, 0, 1, 32'h10, 32'h10, NOP, 0, 0, 1, 1, 4);
    add(0, 0, 0, 0, 1, 32'h10, 32'h10, NOP, 0, 0, 0, 2, 4);
    add(1, 0, 0, 0, 1, 32'h10, 32'h10, NOP, 0, 0, 0, 2, 4);
    add(0, 0, 0, 0, 1, 32'h10, 32'h10, NOP, 0, 1, 1, 2, 4);
    add(0, 0, 0, 0, 1, 32'h10, 32'h14, NOP, 0, 1, 1, 2, 5);
    add(0, 0, 0, 0, 1, 32'h10, 32'h18, NOP, 0, 1, 1, 2, 6);
    add(0, 0, 1, 0, 1, 32'h10, 32'h1c, NOP, 0, 1, 1, 2, 7);
    add(0, 0, 0, 0, 1, 32'h10, 32'h20, NOP, 0, 0, 0, 1, 8);
    // Step 3, then step 0 (treated as 1).
    add(0, 1, 0, 3, 0, 0, 32'h20, NOP, 0, 0, 0, 1, 8);
    add(0, 0, 0, 0, 0, 0, 32'h20, NOP, 0, 1, 2, 1, 8);
    add(0, 0, 0, 0, 0, 0, 32'h24, NOP, 0, 1, 2, 1, 9);
    add(0, 0, 0, 0, 0, 0, 32'h28, NOP, 0, 1, 2, 1, 10);
    add(0, 0, 0, 0, 0, 0, 32'h2c, NOP, 0, 0, 0, 1, 11);
    add(0, 0, 0, 0, 0, 0, 32'h2c, NOP, 0, 0, 0, 1, 11);
    add(0, 1, 0, 0, 0, 0, 32'h2c, NOP, 0, 0, 0, 1, 11);
    add(0, 0, 0, 0, 0, 0, 32'h2c, NOP, 0, 1, 2, 1, 11);
    add(0, 0, 0, 0, 0, 0, 32'h30, NOP, 0, 0, 0, 1, 12);
    add(0, 0, 0, 0, 0, 0, 32'h30, NOP, 0, 0, 0, 1, 12);
    // ECALL on the breakpoint address: ECALL cause wins.
    add(1, 0, 0, 0, 1, 32'h20, 32'h1c, NOP, 0, 0, 0, 1, 12);
    add(0, 0, 0, 0, 1, 32'h20, 32'h1c, NOP, 0, 1, 1, 1, 12);
    add(0, 0, 0, 0, 1, 32'h20, 32'h20, ECL, 0, 0, 1, 1, 13);
    add(0, 0, 0, 0, 1, 32'h20, 32'h20, ECL, 0, 0, 0, 3, 13);
    // Resume past ECALL; halt+run together with a clear while committing.
    add(1, 0, 0, 0, 1, 32'h20, 32'h20, ECL, 0, 0, 0, 3, 13);
    add(0, 0, 0, 0, 1, 32'h20, 32'h20, ECL, 0, 1, 1, 3, 13);
    add(1, 0, 1, 0, 1, 32'h20, 32'h24, NOP, 1, 1, 1, 3, 14);
    add(0, 0, 0, 0, 1, 32'h20, 32'h28, NOP, 0, 0, 0, 1, 0);
    // run beats step when both pulse in HALT.
    add(1, 1, 0, 1, 0, 0, 32'h28, NOP, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 32'h28, NOP, 0, 1, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 32'h2c, NOP, 0, 1, 1, 1, 1);
    add(0, 0, 1, 0, 0, 0, 32'h30, NOP, 0, 1, 1, 1, 2);
    add(0, 0, 0, 0, 0, 0, 32'h34, NOP, 0, 0, 0, 1, 3);
    // Breakpoint hit during a step.
    add(0, 1, 0, 5, 1, 32'h3c, 32'h34, NOP, 0, 0, 0, 1, 3);
    add(0, 0, 0, 0, 1, 32'h3c, 32'h34, NOP, 0, 1, 2, 1, 3);
    add(0, 0, 0, 0, 1, 32'h3c, 32'h38, NOP, 0, 1, 2, 1, 4);
    add(0, 0, 0, 0, 1, 32'h3c, 32'h3c, NOP, 0, 0, 2, 1, 5);
    add(0, 0, 0, 0, 1, 32'h3c, 32'h3c, NOP, 0, 0, 0, 2, 5);

    // Reset
    drive_idle();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #4;
    check_all("reset", 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b1;

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      cmd_run = vecs[i].run; cmd_step = vecs[i].step; cmd_halt = vecs[i].halt;
      step_num = vecs[i].snum; bp_en = vecs[i].bpen; bp_addr = vecs[i].bpaddr;
      pc = vecs[i].pc; inst = vecs[i].inst; cnt_clr = vecs[i].clr;
      #3;
      check_all("vec", i, vecs[i].en, vecs[i].st, vecs[i].cause, vecs[i].ret);
    end

    // Reset asserted mid-step with step_left = 5.
    @(posedge clk);
    #1 drive_idle(); cmd_step = 1; step_num = 8'd7; pc = 32'h100;
    @(posedge clk);
    #1 cmd_step = 0; step_num = 0;
    #3 check("mid.en0", 0, 32'(cpu_en), 32'd1);
    @(posedge clk);
    #4 check("mid.en1", 1, 32'(cpu_en), 32'd1);
    @(posedge clk);
    #2 check("mid.st", 2, 32'(run_state), 32'd2);
    rst = 1'b0;
    #1;
    check_all("rst_mid", 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #4;
      check("post_rst.en", c, 32'(cpu_en), 32'd0);
      check("post_rst.st", c, 32'(run_state), 32'd0);
    end
    check("post_rst.ret", 0, retired, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
